// File: rtl/bsg_bus_pkg.sv
// Shared definitions for the BSG register-window bus arbiter.
package bsg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } bsg_arb_state_t;

  localparam logic [7:0]  BSG_BASE_ADDR = 8'h10;
  localparam int unsigned BSG_NUM_REGS  = 3;
  localparam logic [7:0]  BSG_PARK_ADDR = 8'h00;

  localparam int unsigned BSG_CONTROL_OFS = 0;
  localparam int unsigned BSG_DATA0_OFS   = 1;
  localparam int unsigned BSG_DATA1_OFS   = 2;

endpackage

// File: rtl/bsg_rr_arbiter.sv
// Combinational round-robin winner select; priority starts one past last_i.
module bsg_rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] win_oh_c,
  output logic [IDX_W-1:0] win_idx_c,
  output logic             win_vld_c
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_oh_c  = '0;
    win_idx_c = '0;
    win_vld_c = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = (32'(last_i) + off) % N_REQ;
      if (!win_vld_c && req_i[IDX_W'(idx)]) begin
        win_vld_c = 1'b1;
        win_idx_c = IDX_W'(idx);
        win_oh_c  = N_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/bsg_bus_arbiter.sv
// Round-robin sequencer sharing the BSG register window between requesters,
// one single-beat transaction at a time, with a parked bus while not issuing.
module bsg_bus_arbiter
  import bsg_bus_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           N_REQ      = 3,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = DATA_WIDTH'(BSG_BASE_ADDR),
  parameter int unsigned           N_REGS     = BSG_NUM_REGS,
  parameter logic [DATA_WIDTH-1:0] PARK_ADDR  = DATA_WIDTH'(BSG_PARK_ADDR)
) (
  input  logic                        G_CLK_TX,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            rd,
  input  logic [N_REQ*DATA_WIDTH-1:0] addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic                        err,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        bus_we,
  output logic [DATA_WIDTH-1:0]       bus_addr,
  output logic [DATA_WIDTH-1:0]       bus_wdata,
  input  logic [DATA_WIDTH-1:0]       bus_rdata
);

  localparam int unsigned       IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [DATA_WIDTH:0] WIN_END = (DATA_WIDTH+1)'(BASE_ADDR) + (DATA_WIDTH+1)'(N_REGS);

  bsg_arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [N_REQ-1:0]        done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    bus_we_q, bus_we_d;
  logic [DATA_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;

  logic [N_REQ-1:0]        win_oh;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_vld;
  logic [DATA_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic                    win_in_window;

  bsg_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i     (req),
    .last_i    (last_q),
    .win_oh_c  (win_oh),
    .win_idx_c (win_idx),
    .win_vld_c (win_vld)
  );

  assign win_addr      = addr[win_idx*DATA_WIDTH +: DATA_WIDTH];
  assign win_wdata     = wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
  assign win_in_window = (win_addr >= BASE_ADDR) && ((DATA_WIDTH+1)'(win_addr) < WIN_END);

  // Next state; bus outputs default to the parked read of PARK_ADDR.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    done_d      = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    bus_we_d    = 1'b1;
    bus_addr_d  = PARK_ADDR;
    bus_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          last_d  = win_idx;
          owner_d = win_idx;
          if (!win_in_window) begin
            state_d = DONE;
            done_d  = win_oh;
            err_d   = 1'b1;
          end else begin
            state_d    = ISSUE;
            gnt_d      = win_oh;
            bus_we_d   = rd[win_idx];
            bus_addr_d = win_addr;
            if (!rd[win_idx]) bus_wdata_d = win_wdata;
          end
        end
      end
      ISSUE: begin
        // bus_we_q holds the direction of the transaction being issued
        if (bus_we_q) begin
          state_d = CAPTURE;
        end else begin
          state_d = DONE;
          done_d  = N_REQ'(1) << owner_q;
        end
      end
      CAPTURE: begin
        rdata_d = bus_rdata;
        state_d = DONE;
        done_d  = N_REQ'(1) << owner_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge G_CLK_TX or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(N_REQ - 1);
      owner_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      bus_we_q    <= 1'b1;
      bus_addr_q  <= PARK_ADDR;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_bsg_bus_arbiter.sv
// Directed bench for bsg_bus_arbiter with a behavioural BSG register block on the bus.
module tb_bsg_bus_arbiter;
  import bsg_bus_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  rd;
  logic [23:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        err;
  logic [7:0]  rdata;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;

  int checks   = 0;
  int failures = 0;

  bsg_bus_arbiter dut (
    .G_CLK_TX  (clk),
    .rst       (rst),
    .req       (req),
    .rd        (rd),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register block: writes when bus_we=0 and address hits, read data one edge later.
  logic [7:0] regs [3];
  logic       bhit;
  logic [1:0] bidx;
  assign bhit = (bus_addr >= 8'h10) && (bus_addr < 8'h13);
  assign bidx = 2'(bus_addr - 8'h10);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs[0]   <= 8'h00;
      regs[1]   <= 8'h00;
      regs[2]   <= 8'h00;
      bus_rdata <= 8'h00;
    end else begin
      if (!bus_we && bhit) regs[bidx] <= bus_wdata;
      bus_rdata <= bhit ? regs[bidx] : 8'h00;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic is_rd, input logic [7:0] a, input logic [7:0] d);
    addr[i*8 +: 8]  = a;
    wdata[i*8 +: 8] = d;
    rd[i]           = is_rd;
    req[i]          = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; req = '0; rd = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    checks++; if (done !== 3'b000) begin failures++; $display("FAIL reset_done got=%b exp=000", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    checks++; if (bus_we !== 1'b1) begin failures++; $display("FAIL reset_bus_we got=%b exp=1", bus_we); end
    checks++; if (bus_addr !== 8'h00) begin failures++; $display("FAIL reset_bus_addr got=%h exp=00", bus_addr); end
    checks++; if (bus_wdata !== 8'h00) begin failures++; $display("FAIL reset_bus_wdata got=%h exp=00", bus_wdata); end
  endtask

  task automatic test_write_read();
    set_req(0, 1'b0, BSG_BASE_ADDR + 8'(BSG_DATA0_OFS), 8'hA5);
    tick();
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL wr_gnt got=%b exp=001", gnt); end
    checks++; if (bus_we !== 1'b0) begin failures++; $display("FAIL wr_bus_we got=%b exp=0", bus_we); end
    checks++; if (bus_addr !== 8'h11) begin failures++; $display("FAIL wr_bus_addr got=%h exp=11", bus_addr); end
    checks++; if (bus_wdata !== 8'hA5) begin failures++; $display("FAIL wr_bus_wdata got=%h exp=a5", bus_wdata); end
    checks++; if (done !== 3'b000) begin failures++; $display("FAIL wr_early_done got=%b exp=000", done); end
    tick();
    checks++; if (done !== 3'b001) begin failures++; $display("FAIL wr_done got=%b exp=001", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", err); end
    checks++; if (gnt !== 3'b000 || bus_we !== 1'b1 || bus_addr !== 8'h00) begin
      failures++; $display("FAIL wr_park got gnt=%b we=%b addr=%h exp gnt=000 we=1 addr=00", gnt, bus_we, bus_addr);
    end
    checks++; if (regs[1] !== 8'hA5) begin failures++; $display("FAIL wr_reg got=%h exp=a5", regs[1]); end
    req = '0;
    tick();
    set_req(1, 1'b1, 8'h11, 8'h00);
    tick();
    checks++; if (gnt !== 3'b010 || bus_we !== 1'b1 || bus_addr !== 8'h11) begin
      failures++; $display("FAIL rd_issue got gnt=%b we=%b addr=%h exp gnt=010 we=1 addr=11", gnt, bus_we, bus_addr);
    end
    tick();
    checks++; if (done !== 3'b000) begin failures++; $display("FAIL rd_capture_done got=%b exp=000", done); end
    tick();
    checks++; if (done !== 3'b010) begin failures++; $display("FAIL rd_done got=%b exp=010", done); end
    checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL rd_rdata got=%h exp=a5", rdata); end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    int ng;
    int last_cyc;
    bit req0_again;
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    apply_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 8'(8'h10 + i), 8'(8'h40 + i));
    ng = 0; last_cyc = 0; req0_again = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (gnt !== 3'b000) begin
        checks++;
        if (ng >= 4) begin failures++; $display("FAIL rr_extra_gnt got=%b exp=000", gnt); end
        else if (gnt !== exp_g[ng]) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", ng, gnt, exp_g[ng]); end
        if (ng > 0) begin
          checks++;
          if (c - last_cyc != 3) begin failures++; $display("FAIL rr_spacing%0d got=%0d exp=3", ng, c - last_cyc); end
        end
        last_cyc = c;
        ng++;
      end
      if (done[0]) begin
        if (req0_again) req0_again = 1'b0;
        else req[0] = 1'b0;
      end
      if (done[1]) req[1] = 1'b0;
      if (done[2]) req[2] = 1'b0;
    end
    checks++; if (ng != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", ng); end
    checks++; if (regs[0] !== 8'h40 || regs[2] !== 8'h42) begin
      failures++; $display("FAIL rr_regs got=%h,%h exp=40,42", regs[0], regs[2]);
    end
    req = '0;
  endtask

  task automatic test_err();
    set_req(2, 1'b1, 8'h12, 8'h00);
    repeat (3) tick();
    checks++; if (done !== 3'b100 || rdata !== 8'h42) begin
      failures++; $display("FAIL err_pre_read got done=%b rdata=%h exp done=100 rdata=42", done, rdata);
    end
    req = '0;
    tick();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] a;
      a = (k == 0) ? 8'h13 : 8'h0F;
      set_req(2, 1'b1, a, 8'h00);
      tick();
      checks++; if (done !== 3'b100 || err !== 1'b1) begin
        failures++; $display("FAIL err_done_%h got done=%b err=%b exp done=100 err=1", a, done, err);
      end
      checks++; if (gnt !== 3'b000 || bus_addr !== 8'h00 || bus_we !== 1'b1) begin
        failures++; $display("FAIL err_bus_%h got gnt=%b addr=%h we=%b exp gnt=000 addr=00 we=1", a, gnt, bus_addr, bus_we);
      end
      checks++; if (rdata !== 8'h42) begin failures++; $display("FAIL err_rdata_%h got=%h exp=42", a, rdata); end
      req = '0;
      tick();
      checks++; if (done !== 3'b000 || err !== 1'b0) begin
        failures++; $display("FAIL err_clear_%h got done=%b err=%b exp done=000 err=0", a, done, err);
      end
    end
  endtask

  task automatic test_park();
    set_req(0, 1'b0, BSG_BASE_ADDR + 8'(BSG_CONTROL_OFS), 8'h3C);
    tick();
    tick();
    checks++; if (done !== 3'b001) begin failures++; $display("FAIL park_wr_done got=%b exp=001", done); end
    req = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (bus_we !== 1'b1 || bus_addr !== 8'h00) begin
        failures++; $display("FAIL park_idle%0d got we=%b addr=%h exp we=1 addr=00", c, bus_we, bus_addr);
      end
    end
    checks++; if (regs[0] !== 8'h3C) begin failures++; $display("FAIL park_ctrl got=%h exp=3c", regs[0]); end
    set_req(1, 1'b1, 8'h10, 8'h00);
    repeat (3) tick();
    checks++; if (done !== 3'b010 || rdata !== 8'h3C) begin
      failures++; $display("FAIL park_read got done=%b rdata=%h exp done=010 rdata=3c", done, rdata);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(1, 1'b1, 8'h10, 8'h00);
    tick();
    checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL rmid_gnt got=%b exp=010", gnt); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (done !== 3'b000 || gnt !== 3'b000 || err !== 1'b0) begin
      failures++; $display("FAIL rmid_hs got done=%b gnt=%b err=%b exp all 0", done, gnt, err);
    end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL rmid_rdata got=%h exp=00", rdata); end
    checks++; if (bus_we !== 1'b1 || bus_addr !== 8'h00 || bus_wdata !== 8'h00) begin
      failures++; $display("FAIL rmid_bus got we=%b addr=%h wdata=%h exp we=1 addr=00 wdata=00", bus_we, bus_addr, bus_wdata);
    end
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (done !== 3'b000) begin failures++; $display("FAIL rmid_no_done%0d got=%b exp=000", c, done); end
    end
    checks++; if (regs[0] !== 8'h00) begin failures++; $display("FAIL rmid_regs got=%h exp=00", regs[0]); end
  endtask

  initial begin
    rst = 1'b0; req = '0; rd = '0; addr = '0; wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_err();
    test_park();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_bus_arbiter.md
# bsg_bus_arbiter

Sequences and shares the BSG register window (CONTROL 0x10, DATA_0 0x11, DATA_1 0x12) between N requesters (host, TPU, BD). Accepts single-beat read/write requests, grants them round-robin, drives the shared register-bus signals one transaction at a time, captures read data and returns a completion pulse. It sits between the requesters and the `protocol` register block on the `G_CLK_TX` domain.

## Interface
- `DATA_WIDTH`, 8, data and address width.
- `N_REQ`, 3, number of requesters (0 host, 1 TPU, 2 BD).
- `BASE_ADDR`, 8'h10, first BSG register address.
- `N_REGS`, 3, registers in the window.
- `PARK_ADDR`, 8'h00, address driven while idle; lies outside the window.

- `G_CLK_TX`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  request per requester; held until its `done`.
- `rd`  in  N_REQ  1 = read, 0 = write; stable while `req`.
- `addr`  in  N_REQ*DATA_WIDTH  per-requester address, slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- `wdata`  in  N_REQ*DATA_WIDTH  per-requester write data.
- `gnt`  out  N_REQ  one-hot; high during the bus-issue cycle.
- `done`  out  N_REQ  one-hot; 1-cycle completion pulse.
- `err`  out  1  valid with `done`; address outside window.
- `rdata`  out  DATA_WIDTH  read data; valid with `done` of a read.
- `bus_we`  out  1  to `WRITE_ENABLE`: 1 = read (register to `DATA_OUT`), 0 = write (`DATA_IN` to register).
- `bus_addr`  out  DATA_WIDTH  to `ADDR_IN`.
- `bus_wdata`  out  DATA_WIDTH  to `DATA_IN`.
- `bus_rdata`  in  DATA_WIDTH  from `DATA_OUT`; registered, one edge after issue.

## Operation
- FSM states:
  - IDLE: if any `req`, select the winner. Out-of-window address goes to DONE with `err` and no bus cycle; otherwise load the bus registers and go to ISSUE.
  - ISSUE: drives the winner's transaction. A write goes to DONE. A read goes to CAPTURE.
  - CAPTURE: `rdata <= bus_rdata`; go to DONE.
  - DONE: pulse `done[owner]`; go to IDLE.
- Parking: whenever the state is not ISSUE, bus outputs are `bus_we`=1, `bus_addr`=PARK_ADDR, `bus_wdata`=0. The register block writes on every cycle with `bus_we`=0 and a matching address, so the bus never idles in write mode.
- Window check: `BASE_ADDR <= a < BASE_ADDR+N_REGS`, unsigned, DATA_WIDTH bits. `BASE_ADDR+N_REGS` must not exceed 2^DATA_WIDTH.
- Arbitration: round-robin. Priority starts at `last+1` modulo N_REQ. `last` updates on every selection, including err completions.
- Requests are sampled only in IDLE. `req` still high in the cycle after `done` counts as a new request.
- `err` completions leave `rdata` unchanged.
- Reset values: state IDLE, `last`=N_REQ-1 (requester 0 has first priority), `gnt`=0, `done`=0, `err`=0, `rdata`=0, `bus_we`=1, `bus_addr`=PARK_ADDR, `bus_wdata`=0.

## Timing
- Request seen in IDLE at cycle N:
  - Write: ISSUE/`gnt` at N+1, register updated at the N+1→N+2 edge, `done` at N+2.
  - Read: ISSUE at N+1, CAPTURE at N+2, `done` + `rdata` at N+3.
  - Err: `done` + `err` at N+1.
- Back-to-back: the next IDLE is at DONE+1. Throughput is one write per 3 cycles and one read per 4 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-transaction: immediate return to reset values. The transaction is dropped and no `done` is issued. The protocol block shares `rst`, so its registers also clear.
- Simultaneous requests: exactly one `gnt`/`done` bit per transaction. Losers wait with no starvation; worst-case wait is (N_REQ-1) transactions.

## Structure
- Package `bsg_bus_pkg`:
  - state enum `bsg_arb_state_t` {IDLE, ISSUE, CAPTURE, DONE};
  - `BSG_BASE_ADDR`, `BSG_NUM_REGS`, `BSG_PARK_ADDR`;
  - offsets `BSG_CONTROL_OFS`=0, `BSG_DATA0_OFS`=1, `BSG_DATA1_OFS`=2.
- Sub-module `bsg_rr_arbiter`: combinational winner select from `req` and `last`. Outputs a one-hot and an index. The `last` register stays in the parent.

## Test plan
- Reset → bus parked (`bus_we`=1, `bus_addr`=0x00), all handshake outputs 0. Reset mid-read (in CAPTURE) → no `done`, outputs back to reset values.
- Host write 0x11←0xA5 at N → `gnt[0]` at N+1 with `bus_we`=0/`bus_addr`=0x11/`bus_wdata`=0xA5, `done[0]` at N+2. TPU read 0x11 → `done[1]` with `rdata`=0xA5 at +3.
- All three request writes together after reset → grants in order 0,1,2 on 3-cycle spacing. Requester 0 re-requesting immediately is served after requester 2.
- BD read at 0x13 and at 0x0F → `done[2]`+`err` one cycle later, `bus_addr` stays 0x00, `rdata` unchanged.
- Idle for 20 cycles after writing CONTROL=0x3C → CONTROL still 0x3C (parking causes no spurious writes). Read returns 0x3C.
